// File: rtl/id_stage.sv
// rtl/id_stage.sv - ARM-32 decode/operand-fetch stage with load-use hazard detection and ID/EX register
//
// Purpose: decodes the IF/ID instruction, drives the register file read
// addresses, stalls IF for one bubble on a load-use hazard against EX, and
// owns the ID/EX pipeline register.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   if_valid/if_instr/if_pc     instruction held in the IF/ID latch
//   flush                       branch redirect: kill ID and ID/EX contents
//   ex_hold                     EX cannot accept: freeze ID/EX, stall IF
//   ex_valid/ex_is_load/ex_rd   instruction currently in EX
//   r0addr/r1addr, r0data/r1data  register file asynchronous read ports
//   stall_if                    hold PC and IF/ID this cycle
//   idex_*                      ID/EX pipeline register contents
module id_stage #(
  parameter int data_width = 64,
  parameter int addr_width = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_valid,
  input  logic [31:0]           if_instr,
  input  logic [31:0]           if_pc,
  input  logic                  flush,
  input  logic                  ex_hold,
  input  logic                  ex_valid,
  input  logic                  ex_is_load,
  input  logic [addr_width-1:0] ex_rd,
  output logic [addr_width-1:0] r0addr,
  output logic [addr_width-1:0] r1addr,
  input  logic [data_width-1:0] r0data,
  input  logic [data_width-1:0] r1data,
  output logic                  stall_if,
  output logic                  idex_valid,
  output logic [3:0]            idex_op,
  output logic [addr_width-1:0] idex_rd,
  output logic [addr_width-1:0] idex_rn,
  output logic [addr_width-1:0] idex_rm,
  output logic [data_width-1:0] idex_opa,
  output logic [data_width-1:0] idex_opb,
  output logic [data_width-1:0] idex_imm,
  output logic                  idex_wena,
  output logic                  idex_is_load,
  output logic                  idex_is_store,
  output logic [31:0]           idex_pc
);

  typedef enum logic {RUN = 1'b0, BUBBLE = 1'b1} state_t;

  state_t                state_q, state_d;
  logic                  valid_q, valid_d;
  logic [3:0]            op_q, op_d;
  logic [addr_width-1:0] rd_q, rd_d, rn_q, rn_d, rm_q, rm_d;
  logic [data_width-1:0] opa_q, opa_d, opb_q, opb_d, imm_q, imm_d;
  logic                  wena_q, wena_d, load_q, load_d, store_q, store_d;
  logic [31:0]           pc_q, pc_d;
  logic                  stall_c;

  // Decoded fields of the IF/ID instruction
  logic [3:0]            dec_op;
  logic [addr_width-1:0] dec_rd, dec_rn, dec_rm;
  logic [data_width-1:0] dec_imm;
  logic                  uses_rn, uses_rm, writes_rd, dec_load, dec_store;
  logic                  haz;

  assign dec_op  = if_instr[31:28];
  assign dec_rd  = addr_width'(if_instr[27:24]);
  assign dec_rn  = addr_width'(if_instr[23:20]);
  assign dec_rm  = addr_width'(if_instr[19:16]);
  assign dec_imm = {{(data_width-16){if_instr[15]}}, if_instr[15:0]};

  assign r0addr = dec_rn;
  assign r1addr = dec_rm;

  always_comb begin
    uses_rn   = 1'b0;
    uses_rm   = 1'b0;
    writes_rd = 1'b0;
    dec_load  = 1'b0;
    dec_store = 1'b0;
    case (dec_op)
      4'd1, 4'd2, 4'd3, 4'd4: begin
        uses_rn   = 1'b1;
        uses_rm   = 1'b1;
        writes_rd = 1'b1;
      end
      4'd5: begin
        uses_rn   = 1'b1;
        writes_rd = 1'b1;
      end
      4'd6: begin
        uses_rn   = 1'b1;
        writes_rd = 1'b1;
        dec_load  = 1'b1;
      end
      4'd7: begin
        uses_rn   = 1'b1;
        uses_rm   = 1'b1;
        dec_store = 1'b1;
      end
      4'd8: begin
        uses_rn = 1'b1;
        uses_rm = 1'b1;
      end
      default: ;
    endcase
  end

  assign haz = if_valid & ex_valid & ex_is_load & (ex_rd != '0) &
               ((uses_rn & (dec_rn == ex_rd)) | (uses_rm & (dec_rm == ex_rd)));

  always_comb begin
    valid_d = valid_q;
    op_d    = op_q;
    rd_d    = rd_q;
    rn_d    = rn_q;
    rm_d    = rm_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    imm_d   = imm_q;
    wena_d  = wena_q;
    load_d  = load_q;
    store_d = store_q;
    pc_d    = pc_q;
    stall_c = 1'b0;
    // BUBBLE lasts exactly one cycle; only a fresh hazard re-enters it.
    case (state_q)
      BUBBLE:  state_d = RUN;
      default: state_d = RUN;
    endcase

    if (flush || (!ex_hold && (haz || !if_valid))) begin
      // Flush, bubble and empty slot all load a fully cleared entry.
      valid_d = 1'b0;
      op_d    = '0;
      rd_d    = '0;
      rn_d    = '0;
      rm_d    = '0;
      opa_d   = '0;
      opb_d   = '0;
      imm_d   = '0;
      wena_d  = 1'b0;
      load_d  = 1'b0;
      store_d = 1'b0;
      pc_d    = '0;
      if (!flush && haz) begin
        stall_c = 1'b1;
        state_d = BUBBLE;
      end
    end else if (ex_hold) begin
      stall_c = 1'b1;
    end else begin
      valid_d = 1'b1;
      op_d    = dec_op;
      rd_d    = dec_rd;
      rn_d    = dec_rn;
      rm_d    = dec_rm;
      opa_d   = r0data;
      opb_d   = r1data;
      imm_d   = dec_imm;
      wena_d  = writes_rd & (dec_rd != '0);
      load_d  = dec_load;
      store_d = dec_store;
      pc_d    = if_pc;
    end
  end

  // stall_if must read 0 while reset is held, independent of the inputs.
  assign stall_if = rst_n & stall_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      valid_q <= 1'b0;
      op_q    <= '0;
      rd_q    <= '0;
      rn_q    <= '0;
      rm_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      imm_q   <= '0;
      wena_q  <= 1'b0;
      load_q  <= 1'b0;
      store_q <= 1'b0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      rn_q    <= rn_d;
      rm_q    <= rm_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      imm_q   <= imm_d;
      wena_q  <= wena_d;
      load_q  <= load_d;
      store_q <= store_d;
      pc_q    <= pc_d;
    end
  end

  assign idex_valid    = valid_q;
  assign idex_op       = op_q;
  assign idex_rd       = rd_q;
  assign idex_rn       = rn_q;
  assign idex_rm       = rm_q;
  assign idex_opa      = opa_q;
  assign idex_opb      = opb_q;
  assign idex_imm      = imm_q;
  assign idex_wena     = wena_q;
  assign idex_is_load  = load_q;
  assign idex_is_store = store_q;
  assign idex_pc       = pc_q;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - directed self-checking bench for id_stage
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        flush;
  logic        ex_hold;
  logic        ex_valid;
  logic        ex_is_load;
  logic [3:0]  ex_rd;
  logic [3:0]  r0addr, r1addr;
  logic [63:0] r0data, r1data;
  logic        stall_if;
  logic        idex_valid;
  logic [3:0]  idex_op;
  logic [3:0]  idex_rd, idex_rn, idex_rm;
  logic [63:0] idex_opa, idex_opb, idex_imm;
  logic        idex_wena, idex_is_load, idex_is_store;
  logic [31:0] idex_pc;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Register file stand-in: r0 reads zero, rN reads A5A5_0000_0000_000N.
  function automatic logic [63:0] rf_val(input logic [3:0] a);
    return (a == 4'd0) ? 64'd0 : (64'hA5A5_0000_0000_0000 | 64'(a));
  endfunction
  assign r0data = rf_val(r0addr);
  assign r1data = rf_val(r1addr);

  id_stage #(.data_width(64), .addr_width(4)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .flush(flush), .ex_hold(ex_hold), .ex_valid(ex_valid),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .r0addr(r0addr), .r1addr(r1addr),
    .r0data(r0data), .r1data(r1data), .stall_if(stall_if),
    .idex_valid(idex_valid), .idex_op(idex_op), .idex_rd(idex_rd),
    .idex_rn(idex_rn), .idex_rm(idex_rm), .idex_opa(idex_opa),
    .idex_opb(idex_opb), .idex_imm(idex_imm), .idex_wena(idex_wena),
    .idex_is_load(idex_is_load), .idex_is_store(idex_is_store),
    .idex_pc(idex_pc)
  );

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] rn, input logic [3:0] rm,
                                      input logic [15:0] imm);
    return {op, rd, rn, rm, imm};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] instr, input logic [31:0] pc);
    if_valid = 1'b1;
    if_instr = instr;
    if_pc    = pc;
  endtask

  initial begin
    rst_n = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0; flush = 1'b0;
    ex_hold = 1'b1; ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd = '0;

    // Reset state
    #3;
    chk("rst_valid", 64'(idex_valid), 64'd0);
    chk("rst_stall", 64'(stall_if), 64'd0);
    chk("rst_imm", idex_imm, 64'd0);
    ex_hold = 1'b0;
    tick; tick;
    rst_n = 1'b1;

    // ADDI r3, r0, -5
    present(enc(4'd5, 4'd3, 4'd0, 4'd0, 16'hFFFB), 32'h100);
    #2;
    chk("addi_stall", 64'(stall_if), 64'd0);
    tick;
    chk("addi_valid", 64'(idex_valid), 64'd1);
    chk("addi_op", 64'(idex_op), 64'd5);
    chk("addi_rd", 64'(idex_rd), 64'd3);
    chk("addi_imm", idex_imm, 64'hFFFF_FFFF_FFFF_FFFB);
    chk("addi_opa", idex_opa, 64'd0);
    chk("addi_wena", 64'(idex_wena), 64'd1);
    chk("addi_pc", 64'(idex_pc), 64'h100);

    // ADD r4, r2, r1
    present(enc(4'd1, 4'd4, 4'd2, 4'd1, 16'h0000), 32'h104);
    tick;
    chk("add_opa", idex_opa, 64'hA5A5_0000_0000_0002);
    chk("add_opb", idex_opb, 64'hA5A5_0000_0000_0001);
    chk("add_rn_rm", {56'd0, idex_rn, idex_rm}, 64'h21);

    // ADD r0, r1, r2: rd==0 suppresses write enable
    present(enc(4'd1, 4'd0, 4'd1, 4'd2, 16'h0000), 32'h108);
    tick;
    chk("add_r0_valid", 64'(idex_valid), 64'd1);
    chk("add_r0_wena", 64'(idex_wena), 64'd0);

    // LDR r5, [r1, #8]
    present(enc(4'd6, 4'd5, 4'd1, 4'd0, 16'h0008), 32'h10C);
    tick;
    chk("ldr_ctl", {61'd0, idex_wena, idex_is_load, idex_is_store}, 64'b110);
    chk("ldr_imm", idex_imm, 64'd8);

    // STR r3, [r1]
    present(enc(4'd7, 4'd0, 4'd1, 4'd3, 16'h0000), 32'h110);
    tick;
    chk("str_ctl", {61'd0, idex_wena, idex_is_load, idex_is_store}, 64'b001);
    chk("str_opb", idex_opb, 64'hA5A5_0000_0000_0003);

    // Opcode 12 behaves as NOP: valid, no controls
    present(enc(4'd12, 4'd5, 4'd1, 4'd2, 16'h0000), 32'h114);
    tick;
    chk("nop12_ctl", {60'd0, idex_valid, idex_wena, idex_is_load, idex_is_store}, 64'b1000);

    // Reset mid-stream clears ID/EX without a clock edge
    present(enc(4'd5, 4'd6, 4'd1, 4'd0, 16'h0001), 32'h118);
    tick;
    chk("pre_rst_valid", 64'(idex_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(idex_valid), 64'd0);
    chk("async_rst_wena", 64'(idex_wena), 64'd0);
    #1;
    rst_n = 1'b1;
    present(enc(4'd5, 4'd6, 4'd1, 4'd0, 16'h0001), 32'h11C);
    tick;
    chk("post_rst_valid", 64'(idex_valid), 64'd1);
    chk("post_rst_pc", 64'(idex_pc), 64'h11C);

    // Load-use: LDR r2 in EX, ADD r4, r2, r1 in ID
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 4'd2;
    present(enc(4'd1, 4'd4, 4'd2, 4'd1, 16'h0000), 32'h120);
    #2;
    chk("haz_stall", 64'(stall_if), 64'd1);
    tick;
    chk("haz_bubble_valid", 64'(idex_valid), 64'd0);
    chk("haz_bubble_wena", 64'(idex_wena), 64'd0);
    ex_valid = 1'b0;
    #2;
    chk("haz_no_second", 64'(stall_if), 64'd0);
    tick;
    chk("haz_add_valid", 64'(idex_valid), 64'd1);
    chk("haz_add_rd", 64'(idex_rd), 64'd4);
    chk("haz_add_pc", 64'(idex_pc), 64'h120);

    // Hazard through the rm field: ADD r4, r1, r2
    ex_valid = 1'b1; ex_rd = 4'd2;
    present(enc(4'd1, 4'd4, 4'd1, 4'd2, 16'h0000), 32'h124);
    #2;
    chk("haz_rm_stall", 64'(stall_if), 64'd1);
    tick;
    ex_valid = 1'b0;
    tick;

    // ex_rd == 0 never stalls
    ex_valid = 1'b1; ex_rd = 4'd0;
    present(enc(4'd1, 4'd4, 4'd0, 4'd1, 16'h0000), 32'h128);
    #2;
    chk("exrd0_stall", 64'(stall_if), 64'd0);
    tick;
    chk("exrd0_valid", 64'(idex_valid), 64'd1);

    // ADDI r4, r5 with r2 only in the unused rm field
    ex_rd = 4'd2;
    present(enc(4'd5, 4'd4, 4'd5, 4'd2, 16'h0010), 32'h12C);
    #2;
    chk("addi_rm_stall", 64'(stall_if), 64'd0);
    tick;
    chk("addi_rm_opa", idex_opa, 64'hA5A5_0000_0000_0005);

    // Back-to-back loads to distinct registers: LDR r3, [r1]
    present(enc(4'd6, 4'd3, 4'd1, 4'd0, 16'h0000), 32'h130);
    #2;
    chk("ldld_stall", 64'(stall_if), 64'd0);
    tick;
    chk("ldld_load", 64'(idex_is_load), 64'd1);

    // flush with haz and ex_hold: flush wins
    ex_hold = 1'b1; flush = 1'b1;
    present(enc(4'd1, 4'd4, 4'd2, 4'd1, 16'h0000), 32'h134);
    #2;
    chk("flush_stall", 64'(stall_if), 64'd0);
    tick;
    chk("flush_valid", 64'(idex_valid), 64'd0);
    chk("flush_ctl", {61'd0, idex_wena, idex_is_load, idex_is_store}, 64'd0);
    flush = 1'b0; ex_hold = 1'b0; ex_valid = 1'b0; ex_is_load = 1'b0;
    present(enc(4'd2, 4'd8, 4'd1, 4'd2, 16'h0000), 32'h138);
    tick;
    chk("post_flush_op", 64'(idex_op), 64'd2);

    // ex_hold for three cycles
    present(enc(4'd5, 4'd6, 4'd1, 4'd0, 16'h1234), 32'h140);
    tick;
    ex_hold = 1'b1;
    present(enc(4'd2, 4'd7, 4'd2, 4'd3, 16'h0000), 32'h144);
    for (int c = 0; c < 3; c++) begin
      #2;
      chk("hold_stall", 64'(stall_if), 64'd1);
      tick;
      chk("hold_rd", 64'(idex_rd), 64'd6);
      chk("hold_imm", idex_imm, 64'h1234);
      chk("hold_opa", idex_opa, 64'hA5A5_0000_0000_0001);
      chk("hold_pc", 64'(idex_pc), 64'h140);
    end
    ex_hold = 1'b0;
    #2;
    chk("unhold_stall", 64'(stall_if), 64'd0);
    tick;
    chk("unhold_rd", 64'(idex_rd), 64'd7);
    chk("unhold_op", 64'(idex_op), 64'd2);
    chk("unhold_opb", idex_opb, 64'hA5A5_0000_0000_0003);

    // Empty IF/ID slot produces an invalid entry
    if_valid = 1'b0;
    tick;
    chk("empty_valid", 64'(idex_valid), 64'd0);
    chk("empty_wena", 64'(idex_wena), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Decode/operand-fetch stage of the ARM-32 pipeline. Sits between the IF/ID latch and the EX stage, drives the register file's two asynchronous read ports, detects load-use hazards against the instruction in EX, and owns the ID/EX pipeline register. Write-back-to-read hazards are covered by the register file's same-cycle write bypass. EX/MEM-to-EX forwarding is done downstream using the source addresses this stage registers.

## Interface
- data_width, 64, operand/register width
- addr_width, 4, register address width; register 0 reads as zero
- clk  in  1  pipeline clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_valid  in  1  IF/ID holds a valid instruction
- if_instr  in  32  instruction word
- if_pc  in  32  PC of if_instr
- flush  in  1  branch redirect from EX; kill the ID instruction and the ID/EX contents
- ex_hold  in  1  EX cannot accept; freeze the ID/EX register
- ex_valid, ex_is_load  in  1 each  instruction currently in EX is valid / is a load
- ex_rd  in  addr_width  destination of the EX instruction
- r0addr, r1addr  out  addr_width  register file read addresses (combinational from if_instr)
- r0data, r1data  in  data_width  register file read data
- stall_if  out  1  hold PC and the IF/ID latch this cycle
- idex_valid  out  1  ID/EX holds a valid instruction
- idex_op  out  4  opcode
- idex_rd, idex_rn, idex_rm  out  addr_width each  destination and source addresses
- idex_opa, idex_opb  out  data_width each  rn and rm operand values
- idex_imm  out  data_width  sign-extended imm16
- idex_wena, idex_is_load, idex_is_store  out  1 each  decoded control
- idex_pc  out  32  PC of the instruction

## Operation
- Fields: op = instr[31:28], rd = [27:24], rn = [23:20], rm = [19:16], imm16 = [15:0]. imm is sign-extended to data_width. With addr_width greater than 4, the register fields are zero-extended.
- Opcodes:
  - 0 NOP
  - 1 ADD, 2 SUB, 3 AND, 4 ORR: use rn and rm, write rd
  - 5 ADDI: uses rn, writes rd
  - 6 LDR: uses rn, writes rd, is_load
  - 7 STR: uses rn and rm, is_store
  - 8 BEQ: uses rn and rm
  - 9-15: treated as NOP
- wena is forced to 0 when rd == 0.
- r0addr = rn and r1addr = rm, driven regardless of valid.
- Hazard (combinational):
  - haz = if_valid & ex_valid & ex_is_load & (ex_rd != 0) & ((uses_rn & rn == ex_rd) | (uses_rm & rm == ex_rd)).
- FSM, two states:
  - RUN: normal operation.
  - BUBBLE: entered for exactly one cycle after a bubble is injected for haz; returns to RUN unconditionally.
  - Because the load has left EX by the next cycle, haz cannot re-fire for the same pair.
- ID/EX update priority, highest first:
  - flush: idex_valid <= 0, all control cleared, stall_if = 0, state <= RUN.
  - ex_hold: ID/EX holds every field, stall_if = 1.
  - haz: idex_valid <= 0 with controls cleared (bubble), stall_if = 1, state <= BUBBLE.
  - otherwise: load the decoded instruction; idex_valid <= if_valid; stall_if = 0.
- A bubble or invalid entry always carries wena = is_load = is_store = 0. Data fields are don't-care, but a bench may check for 0.

## Timing
- Reset: all idex_* outputs are 0 and state is RUN. stall_if is 0 while rst_n is low.
- Reset asserted mid-operation clears ID/EX immediately, without waiting for a clock edge.
- Decode and operand read are combinational; an instruction presented in IF/ID in cycle N appears on idex_* after the edge ending cycle N. Latency is 1 cycle when there is no stall.
- Load-use costs exactly one bubble.
- stall_if is combinational in the same cycle as haz or ex_hold, so IF must not advance at that edge.
- A register written by WB in the same cycle the instruction is in ID is captured with the new value, via the register file bypass. This stage adds no logic for that case.
- flush together with haz or ex_hold: flush wins, and the held or stalled instruction is discarded.
- Back-to-back loads to distinct registers do not stall.

## Test plan
- Reset mid-stream: assert rst_n=0 while idex_valid=1. Required: idex_valid and idex_wena go to 0 before the next edge; after release, the first instruction appears 1 cycle later.
- ADDI r3, r0, -5 (imm16 = 0xFFFB). Required: idex_imm = 0xFFFF_FFFF_FFFF_FFFB, idex_opa = 0, idex_wena = 1, idex_rd = 3.
- LDR r2 in EX (ex_valid=1, ex_is_load=1, ex_rd=2), ADD r4, r2, r1 in ID. Required:
  - Cycle 1: stall_if = 1, a bubble with idex_valid = 0 enters ID/EX.
  - Next cycle: with ex_valid=0, stall_if = 0 and the ADD loads.
  - No second bubble.
- Same hazard setup but ex_rd = 0, or a consumer ADDI r4, r5 with r2 only in the rm field. Required: no stall.
- flush asserted together with haz and ex_hold. Required: idex_valid = 0, stall_if = 0, state = RUN.
- ex_hold held for 3 cycles. Required: idex_* stable across all 3 cycles, stall_if = 1 throughout; the next instruction loads on the cycle after ex_hold drops.
